ov7670_stream_gen: RTL and testbench

//  Parametrised OV7670 sensor emulator: drives PCLK/VSYNC/HREF/D exactly as the camera does,

---
 rtl/ov7670_stream_gen.sv | 186 ++++++++++++++++++
 tb/tb_ov7670_stream_gen.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_stream_gen.sv
// OV7670 camera emulator: PCLK/VSYNC/HREF/D timing with selectable RGB565 test patterns.
// All frame outputs are registered and change only on the PCLK falling-edge tick.
module ov7670_stream_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int PCLK_DIV    = 2,
    parameter int FCNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [15:0]       const_rgb,
    output logic              PCLK,
    output logic              VSYNC,
    output logic              HREF,
    output logic [7:0]        D,
    output logic              frame_start,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int              DW         = $clog2(PCLK_DIV);
    localparam logic [DW-1:0]   DIV_LAST   = DW'(PCLK_DIV - 1);
    localparam logic [DW-1:0]   DIV_HALF   = DW'(PCLK_DIV / 2);
    localparam logic [15:0]     LINE_M1    = 16'(2 * H_ACTIVE + H_BLANK - 1);
    localparam logic [15:0]     HREF_TICKS = 16'(2 * H_ACTIVE);
    localparam logic [15:0]     BAR_W      = 16'(H_ACTIVE / 8);
    localparam logic [FCNT_W-1:0] FCNT_ONE = {{(FCNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

    logic [DW-1:0]     r_div;
    logic              r_pclk;
    state_t            r_state;
    logic [15:0]       r_h;
    logic [15:0]       r_v;
    logic [1:0]        r_mode;
    logic [15:0]       r_const;
    logic              r_vsync;
    logic              r_href;
    logic [7:0]        r_d;
    logic              r_fs;
    logic [FCNT_W-1:0] r_fcnt;

    logic [DW-1:0]     w_div_inc;
    logic              w_tick;
    state_t            w_state;
    logic [15:0]       w_h;
    logic [15:0]       w_v;
    logic              w_entry;
    logic [15:0]       w_x;
    logic [15:0]       w_pix;
    logic              w_href;
    logic [7:0]        w_byte;

    function automatic logic [15:0] lines_of(input state_t s);
        case (s)
            S_VSYNC:  lines_of = 16'(VSYNC_LINES);
            S_VBACK:  lines_of = 16'(V_BACK);
            S_ACTIVE: lines_of = 16'(V_ACTIVE);
            default:  lines_of = 16'(V_FRONT);
        endcase
    endfunction

    function automatic logic [15:0] pattern(input logic [1:0] m, input logic [15:0] c,
                                            input logic [15:0] x, input logic y3);
        logic [15:0] bar;
        logic [5:0]  g;
        bar = x / BAR_W;
        g   = x[5:0];
        case (m)
            2'd0: begin
                case (bar)
                    16'd0:   pattern = 16'hFFFF;
                    16'd1:   pattern = 16'hFFE0;
                    16'd2:   pattern = 16'h07FF;
                    16'd3:   pattern = 16'h07E0;
                    16'd4:   pattern = 16'hF81F;
                    16'd5:   pattern = 16'hF800;
                    16'd6:   pattern = 16'h001F;
                    default: pattern = 16'h0000;
                endcase
            end
            2'd1:    pattern = {g[5:1], g, g[5:1]};
            2'd2:    pattern = (x[3] ^ y3) ? 16'hFFFF : 16'h0000;
            default: pattern = c;
        endcase
    endfunction

    assign w_div_inc = r_div + DW'(1);
    assign w_tick    = (r_div == DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div  <= '0;
            r_pclk <= 1'b0;
        end else if (w_tick) begin
            r_div  <= '0;
            r_pclk <= 1'b0;
        end else begin
            r_div <= w_div_inc;
            if (w_div_inc == DIV_HALF) r_pclk <= 1'b1;
        end
    end

    // Raster position the outputs will show after the coming tick; line ends drive state changes.
    always_comb begin
        w_state = r_state;
        w_h     = r_h;
        w_v     = r_v;
        w_entry = 1'b0;
        if (r_state == S_IDLE) begin
            if (en) begin
                w_state = S_VSYNC;
                w_h     = '0;
                w_v     = '0;
                w_entry = 1'b1;
            end
        end else if (r_h == LINE_M1) begin
            w_h = '0;
            if (r_v == lines_of(r_state) - 16'd1) begin
                w_v = '0;
                case (r_state)
                    S_VSYNC:  w_state = S_VBACK;
                    S_VBACK:  w_state = S_ACTIVE;
                    S_ACTIVE: w_state = S_VFRONT;
                    default: begin
                        w_state = en ? S_VSYNC : S_IDLE;
                        w_entry = en;
                    end
                endcase
            end else begin
                w_v = r_v + 16'd1;
            end
        end else begin
            w_h = r_h + 16'd1;
        end
    end

    assign w_x    = {1'b0, w_h[15:1]};
    assign w_pix  = pattern(r_mode, r_const, w_x, w_v[3]);
    assign w_href = (w_state == S_ACTIVE) && (w_h < HREF_TICKS);
    assign w_byte = w_h[0] ? w_pix[7:0] : w_pix[15:8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_h     <= '0;
            r_v     <= '0;
            r_mode  <= '0;
            r_const <= '0;
            r_vsync <= 1'b0;
            r_href  <= 1'b0;
            r_d     <= '0;
            r_fs    <= 1'b0;
            r_fcnt  <= '0;
        end else if (w_tick) begin
            r_state <= w_state;
            r_h     <= w_h;
            r_v     <= w_v;
            r_vsync <= (w_state == S_VSYNC);
            r_href  <= w_href;
            r_d     <= w_href ? w_byte : 8'h00;
            r_fs    <= w_entry;
            if (w_entry) begin
                r_fcnt  <= r_fcnt + FCNT_ONE;
                r_mode  <= mode;
                r_const <= const_rgb;
            end
        end else begin
            r_fs <= 1'b0;
        end
    end

    assign PCLK        = r_pclk;
    assign VSYNC       = r_vsync;
    assign HREF        = r_href;
    assign D           = r_d;
    assign frame_start = r_fs;
    assign frame_cnt   = r_fcnt;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Bench for ov7670_stream_gen: requested frames are queued as descriptors, a monitor expands
// each into the expected per-PCLK {VSYNC,HREF,D} stream and compares every sample.
module tb_ov7670_stream_gen;

    localparam int HA = 16, VA = 8, HB = 4, VSL = 1, VB = 1, VF = 1, DIV = 2, FW = 2;
    localparam int LINE = 2 * HA + HB;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [15:0]   const_rgb = 16'h0000;
    logic          PCLK, VSYNC, HREF, frame_start;
    logic [7:0]    D;
    logic [FW-1:0] frame_cnt;

    ov7670_stream_gen #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .VSYNC_LINES(VSL), .V_BACK(VB),
        .V_FRONT(VF), .PCLK_DIV(DIV), .FCNT_W(FW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .const_rgb(const_rgb),
        .PCLK(PCLK), .VSYNC(VSYNC), .HREF(HREF), .D(D),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { int m; int c; } desc_t;

    int          total = 0;
    int          bad = 0;
    desc_t       desc_q[$];
    logic [9:0]  exp_q[$];
    bit          in_frame = 0;
    int          vs_n = 0;
    int          fs_n = 0;
    int          fs_model = 0;
    bit          prev_fs = 0;
    int          fm[8];
    int          fc[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int model_pix(input int m, input int c, input int x, input int y);
        int g;
        case (m)
            0: begin
                case (x / (HA / 8))
                    0: return 'hFFFF;
                    1: return 'hFFE0;
                    2: return 'h07FF;
                    3: return 'h07E0;
                    4: return 'hF81F;
                    5: return 'hF800;
                    6: return 'h001F;
                    default: return 'h0000;
                endcase
            end
            1: begin
                g = x % 64;
                return ((g / 2) << 11) | (g << 5) | (g / 2);
            end
            2: return (((x / 8) % 2) != ((y / 8) % 2)) ? 'hFFFF : 'h0000;
            default: return c & 'hFFFF;
        endcase
    endfunction

    task automatic build_frame(input int m, input int c);
        int pix;
        logic [7:0] b8;
        for (int i = 0; i < VSL * LINE; i++) exp_q.push_back({1'b1, 1'b0, 8'h00});
        for (int i = 0; i < VB * LINE; i++)  exp_q.push_back(10'h000);
        for (int y = 0; y < VA; y++) begin
            for (int b = 0; b < 2 * HA; b++) begin
                pix = model_pix(m, c, b / 2, y);
                b8  = (b % 2 == 0) ? 8'((pix >> 8) & 'hFF) : 8'(pix & 'hFF);
                exp_q.push_back({1'b0, 1'b1, b8});
            end
            for (int i = 0; i < HB; i++) exp_q.push_back(10'h000);
        end
        for (int i = 0; i < VF * LINE; i++) exp_q.push_back(10'h000);
    endtask

    // Sample each PCLK period mid-high, i.e. where a receiver latching on PCLK rise would.
    always @(negedge clk) begin
        desc_t d;
        logic [9:0] e;
        if (!rst) begin
            in_frame = 0;
            exp_q.delete();
            vs_n = 0;
        end else if (PCLK) begin
            if (!in_frame && VSYNC) begin
                vs_n++;
                if (desc_q.size() == 0) begin
                    chk("unexpected_frame", 32'(desc_q.size()), 32'd1);
                end else begin
                    d = desc_q.pop_front();
                    build_frame(d.m, d.c);
                    in_frame = 1;
                    chk("fs_before_vsync", 32'(fs_n), 32'(vs_n));
                end
            end
            if (in_frame) begin
                e = exp_q.pop_front();
                chk("frame_sample", {22'd0, VSYNC, HREF, D}, {22'd0, e});
                if (exp_q.size() == 0) in_frame = 0;
            end else begin
                chk("idle_sample", {22'd0, VSYNC, HREF, D}, 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            fs_n = 0;
            fs_model = 0;
            prev_fs = 0;
        end else begin
            if (frame_start) begin
                fs_n++;
                fs_model = (fs_model + 1) % (1 << FW);
                chk("frame_cnt", 32'(frame_cnt), 32'(fs_model));
                chk("fs_with_vsync", 32'(VSYNC), 32'd1);
                chk("fs_width", 32'(prev_fs), 32'd0);
            end
            prev_fs = frame_start;
        end
    end

    task automatic wait_fs(input string tag);
        bit found = 0;
        for (int k = 0; k < 3000 && !found; k++) begin
            @(negedge clk);
            if (frame_start) found = 1;
        end
        chk({"fs_timeout_", tag}, 32'(found), 32'd1);
    endtask

    // Runs n frames from fm/fc; mid-frame junk on mode/const must not leak into the current frame.
    task automatic run_frames(input int n, input int drop_lo, input int drop_hi);
        mode      = 2'(fm[0]);
        const_rgb = 16'(fc[0]);
        desc_q.push_back('{fm[0], fc[0]});
        en = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_fs("run");
            mode      = 2'($urandom_range(0, 3));
            const_rgb = 16'($urandom);
            if (i < n - 1) begin
                repeat ($urandom_range(5, 300)) @(negedge clk);
                mode      = 2'(fm[i+1]);
                const_rgb = 16'(fc[i+1]);
                desc_q.push_back('{fm[i+1], fc[i+1]});
            end else begin
                repeat ($urandom_range(drop_lo, drop_hi)) @(negedge clk);
                en = 1'b0;
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pclk"}, 32'(PCLK), 32'd0);
        chk({tag, "_vsync"}, 32'(VSYNC), 32'd0);
        chk({tag, "_href"}, 32'(HREF), 32'd0);
        chk({tag, "_d"}, 32'(D), 32'd0);
        chk({tag, "_fs"}, 32'(frame_start), 32'd0);
        chk({tag, "_fcnt"}, 32'(frame_cnt), 32'd0);
    endtask

    initial begin
        bit seen;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            chk("idle_pclk", 32'(PCLK), 32'(k % 2));
            chk("idle_fcnt", 32'(frame_cnt), 32'd0);
        end

        // Bars, checker, constant (with bars latched after it), grey, then two random frames;
        // en drops inside active line 3 of the last one.
        fm = '{0, 2, 3, 0, 1, 0, 0, 0};
        fc = '{0, 0, 'hA5C3, 0, 0, 0, 0, 0};
        for (int i = 5; i < 7; i++) begin
            fm[i] = int'($urandom_range(0, 3));
            fc[i] = int'($urandom_range(0, 'hFFFF));
        end
        run_frames(7, 362, 426);
        repeat (1200) @(negedge clk);
        chk("stop_fcnt", 32'(frame_cnt), 32'(7 % (1 << FW)));
        chk("stop_vsync", 32'(VSYNC), 32'd0);
        chk("stop_desc_left", 32'(desc_q.size()), 32'd0);
        chk("stop_in_frame", 32'(in_frame), 32'd0);

        // Asynchronous reset while HREF is high, then restart counting from 1 and wrap.
        mode = 2'd0;
        desc_q.push_back('{0, 0});
        en = 1'b1;
        wait_fs("pre_reset");
        seen = 0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            @(negedge clk);
            if (HREF) seen = 1;
        end
        chk("href_timeout", 32'(seen), 32'd1);
        repeat ($urandom_range(0, 20)) @(negedge clk);
        en = 1'b0;
        #2 rst = 1'b0;
        #1 chk_reset_outputs("async_rst");
        repeat (3) @(negedge clk);
        chk("rst_desc_left", 32'(desc_q.size()), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fm[i] = int'($urandom_range(0, 3));
            fc[i] = int'($urandom_range(0, 'hFFFF));
        end
        run_frames(4, 1, 100);
        repeat (1200) @(negedge clk);
        chk("wrap_fcnt", 32'(frame_cnt), 32'd0);
        chk("end_desc_left", 32'(desc_q.size()), 32'd0);
        chk("end_in_frame", 32'(in_frame), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
